// File: rtl/prog_mem_pkg.sv
// Shared definitions for the writable program memory:
// load-FSM states, default instruction word, byte-counter sizing.
package prog_mem_pkg;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_LOAD = 1'b1
   } state_t;

   localparam logic [3:0]  LED = 4'h4;
   localparam logic [27:0] DEFAULT_INSTR = {LED, 24'b10101010};

   function automatic int cnt_width(input int bytes);
      return (bytes > 1) ? $clog2(bytes) : 1;
   endfunction

endpackage

// File: rtl/prog_mem_byte_assembler.sv
// Packs a little-endian byte stream into instruction words;
// word/word_done are combinational so the completing edge writes.
module prog_mem_byte_assembler
   import prog_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 28
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  flush,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_in,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_done,
   output logic                  partial_drop
);

   localparam int BYTES = (DATA_WIDTH + 7) / 8;
   localparam int CW    = cnt_width(BYTES);

   logic [CW-1:0]      cnt;
   logic [CW-1:0]      cnt_next;
   logic [BYTES*8-1:0] acc;
   logic [BYTES*8-1:0] merged;
   logic               last;

   assign last = (cnt == CW'(BYTES - 1));

   always_comb begin
      merged = acc;
      merged[8*cnt +: 8] = byte_in;
   end

   always_comb begin
      cnt_next = cnt;
      if (byte_valid)
         cnt_next = last ? '0 : cnt + CW'(1);
   end

   assign word         = merged[DATA_WIDTH-1:0];
   assign word_done    = byte_valid & last;
   assign partial_drop = flush & (cnt_next != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         acc <= '0;
      end else begin
         if (clear | flush)
            cnt <= '0;
         else
            cnt <= cnt_next;
         if (byte_valid)
            acc <= merged;
      end
   end

endmodule

// File: rtl/prog_mem.sv
// Writable instruction memory with registered one-cycle fetch
// and a byte-stream loader that refills it at run time.
module prog_mem
   import prog_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 28,
   parameter int DEPTH      = 64,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD =
      DATA_WIDTH'(DEFAULT_INSTR)
)(
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [15:0]           iAddress,
   input  logic                  iReadEnable,
   output logic [DATA_WIDTH-1:0] oInstruction,
   output logic                  oInstructionValid,
   input  logic                  iLoadStart,
   input  logic [7:0]            iLoadByte,
   input  logic                  iLoadByteValid,
   output logic                  oLoadByteReady,
   input  logic                  iLoadEnd,
   output logic                  oBusy,
   output logic [15:0]           oWordCount,
   output logic                  oLoadError
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = $clog2(DEPTH + 1);
   localparam logic [16:0] LIMIT = 17'(DEPTH);

   state_t                state;
   state_t                state_next;
   logic [PW-1:0]         wptr;
   logic                  full;
   logic                  accept;
   logic                  start_go;
   logic                  end_go;
   logic                  in_range;
   logic                  word_done;
   logic                  partial_drop;
   logic [DATA_WIDTH-1:0] word;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)
         state <= S_RUN;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_RUN:  if (iLoadStart) state_next = S_LOAD;
         S_LOAD: if (iLoadEnd)   state_next = S_RUN;
         default: state_next = S_RUN;
      endcase
   end

   always_comb begin
      oBusy          = 1'b0;
      oLoadByteReady = 1'b0;
      if (state == S_LOAD) begin
         oBusy          = 1'b1;
         oLoadByteReady = ~full;
      end
   end

   assign full     = (wptr == PW'(DEPTH));
   assign accept   = iLoadByteValid & oLoadByteReady;
   assign start_go = (state == S_RUN) & iLoadStart;
   assign end_go   = oBusy & iLoadEnd;
   assign in_range = {1'b0, iAddress} < LIMIT;

   prog_mem_byte_assembler #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_byte_assembler (
      .clk          (Clock),
      .rst_n        (Reset),
      .clear        (start_go),
      .flush        (end_go),
      .byte_valid   (accept),
      .byte_in      (iLoadByte),
      .word         (word),
      .word_done    (word_done),
      .partial_drop (partial_drop)
   );

   // Array is deliberately not reset so programs survive a reset.
   always_ff @(posedge Clock) begin
      if (word_done)
         mem[wptr[AW-1:0]] <= word;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         oInstruction      <= DEFAULT_WORD;
         oInstructionValid <= 1'b0;
      end else if (iReadEnable) begin
         if (oBusy) begin
            oInstruction      <= DEFAULT_WORD;
            oInstructionValid <= 1'b0;
         end else if (in_range) begin
            oInstruction      <= mem[iAddress[AW-1:0]];
            oInstructionValid <= 1'b1;
         end else begin
            oInstruction      <= DEFAULT_WORD;
            oInstructionValid <= 1'b1;
         end
      end else begin
         oInstructionValid <= 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         wptr       <= '0;
         oWordCount <= '0;
         oLoadError <= 1'b0;
      end else if (start_go) begin
         wptr       <= '0;
         oWordCount <= '0;
         oLoadError <= 1'b0;
      end else begin
         if (word_done) begin
            wptr       <= wptr + PW'(1);
            oWordCount <= oWordCount + 16'd1;
         end
         if ((oBusy & full & iLoadByteValid) | partial_drop)
            oLoadError <= 1'b1;
      end
   end

endmodule

// File: tb/tb_prog_mem.sv
// Randomized scoreboard bench for prog_mem against a byte-list
// model of the loader and an array model of the memory.
module tb_prog_mem;

   localparam int DW    = 28;
   localparam int DEPTH = 16;
   localparam int BYTES = 4;
   localparam logic [DW-1:0] DEF = 28'h40000AA;

   logic          Clock = 1'b0;
   logic          Reset = 1'b0;
   logic [15:0]   iAddress = '0;
   logic          iReadEnable = 1'b0;
   logic [DW-1:0] oInstruction;
   logic          oInstructionValid;
   logic          iLoadStart = 1'b0;
   logic [7:0]    iLoadByte = '0;
   logic          iLoadByteValid = 1'b0;
   logic          oLoadByteReady;
   logic          iLoadEnd = 1'b0;
   logic          oBusy;
   logic [15:0]   oWordCount;
   logic          oLoadError;

   always #5 Clock = ~Clock;

   prog_mem #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .Clock             (Clock),
      .Reset             (Reset),
      .iAddress          (iAddress),
      .iReadEnable       (iReadEnable),
      .oInstruction      (oInstruction),
      .oInstructionValid (oInstructionValid),
      .iLoadStart        (iLoadStart),
      .iLoadByte         (iLoadByte),
      .iLoadByteValid    (iLoadByteValid),
      .oLoadByteReady    (oLoadByteReady),
      .iLoadEnd          (iLoadEnd),
      .oBusy             (oBusy),
      .oWordCount        (oWordCount),
      .oLoadError        (oLoadError)
   );

   typedef struct {
      int            cyc;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sbq[$];
   exp_t          mon_e;
   int            cyc = 0;
   int            n_chk = 0;
   int            n_fail = 0;

   logic [DW-1:0] m_mem[DEPTH];
   bit            m_known[DEPTH];
   logic [7:0]    pend[$];
   int            m_wptr = 0;
   int            m_wc = 0;
   bit            m_err = 0;
   bit            m_busy = 0;
   logic [7:0]    q[$];

   always @(posedge Clock) cyc++;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Monitor: every valid fetch result must match the oldest
   // outstanding request and arrive exactly one cycle after it.
   always @(negedge Clock) begin
      if (Reset) begin
         while (sbq.size() != 0 && sbq[0].cyc < cyc) begin
            mon_e = sbq.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing_fetch: got nothing, required %0h",
                     mon_e.data);
         end
         if (oInstructionValid) begin
            if (sbq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_fetch: got %0h, required none",
                        oInstruction);
            end else begin
               mon_e = sbq.pop_front();
               chk("fetch_cycle", cyc, mon_e.cyc);
               chk("fetch_data", oInstruction, mon_e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   function automatic logic [DW-1:0] expect_read(input logic [15:0] a);
      if (int'(a) >= DEPTH) return DEF;
      return m_mem[a];
   endfunction

   function automatic logic [15:0] pick_addr();
      int k[$];
      for (int i = 0; i < DEPTH; i++)
         if (m_known[i]) k.push_back(i);
      if (k.size() == 0 || $urandom_range(0, 3) == 0)
         return 16'($urandom_range(DEPTH, 65535));
      return 16'(k[$urandom_range(0, k.size() - 1)]);
   endfunction

   task automatic fetch_req(input logic [15:0] a);
      exp_t e;
      iReadEnable = 1'b1;
      iAddress    = a;
      if (!m_busy) begin
         e.cyc  = cyc + 1;
         e.data = expect_read(a);
         sbq.push_back(e);
      end
   endtask

   task automatic fetch(input logic [15:0] a);
      fetch_req(a);
      tick();
   endtask

   task automatic idle();
      iReadEnable = 1'b0;
      tick();
   endtask

   task automatic check_status();
      chk("busy", oBusy, m_busy);
      chk("word_count", oWordCount, m_wc);
      chk("load_error", oLoadError, m_err);
   endtask

   task automatic finish_model();
      if (pend.size() != 0) m_err = 1;
      pend.delete();
      m_busy = 0;
   endtask

   task automatic start_load(input bit with_read);
      iLoadStart = 1'b1;
      if (with_read) fetch_req(pick_addr());
      tick();
      iLoadStart  = 1'b0;
      iReadEnable = 1'b0;
      m_busy = 1;
      m_wptr = 0;
      m_wc   = 0;
      m_err  = 0;
      pend.delete();
      chk("busy_after_start", oBusy, m_busy);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit with_end);
      bit            rdy;
      bit            exp_rdy;
      logic [31:0]   w;
      iLoadByteValid = 1'b1;
      iLoadByte      = b;
      iLoadEnd       = with_end;
      exp_rdy = (m_wptr < DEPTH);
      rdy     = oLoadByteReady;
      chk("byte_ready", rdy, exp_rdy);
      tick();
      iLoadByteValid = 1'b0;
      iLoadEnd       = 1'b0;
      if (exp_rdy) begin
         pend.push_back(b);
         if (pend.size() == BYTES) begin
            w = '0;
            for (int k = 0; k < BYTES; k++)
               w = w | (32'(pend[k]) << (8 * k));
            m_mem[m_wptr]   = w[DW-1:0];
            m_known[m_wptr] = 1;
            m_wptr++;
            m_wc++;
            pend.delete();
         end
      end else begin
         m_err = 1;
      end
      if (with_end) finish_model();
   endtask

   task automatic end_load();
      iLoadEnd = 1'b1;
      tick();
      iLoadEnd = 1'b0;
      finish_model();
   endtask

   task automatic do_load(input logic [7:0] bytes[$],
                          input bit same_end,
                          input bit with_read);
      start_load(with_read);
      iReadEnable = 1'b1;
      iAddress    = 16'(pick_addr());
      tick();
      iReadEnable = 1'b0;
      chk("load_read_data", oInstruction, DEF);
      chk("load_read_valid", oInstructionValid, 1'b0);
      foreach (bytes[i]) begin
         if ($urandom_range(0, 3) == 0) tick();
         send_byte(bytes[i], same_end && (i == bytes.size() - 1));
      end
      if (!same_end || bytes.size() == 0) end_load();
      check_status();
   endtask

   initial begin
      repeat (3) @(posedge Clock);
      #1;
      chk("rst_instr", oInstruction, DEF);
      chk("rst_valid", oInstructionValid, 1'b0);
      chk("rst_ready", oLoadByteReady, 1'b0);
      check_status();
      Reset = 1'b1;
      tick();
      chk("idle_instr", oInstruction, DEF);
      chk("idle_valid", oInstructionValid, 1'b0);

      q = '{8'h05, 8'h00, 8'h01, 8'h09};
      do_load(q, 0, 0);
      fetch(16'd0);
      fetch(16'd16);
      fetch(16'hFFFF);
      idle();

      q.delete();
      for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
      do_load(q, 0, 1);
      fetch(16'd0);
      fetch(16'd1);
      fetch(16'd0);
      idle();

      q.delete();
      for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
      do_load(q, 0, 0);
      fetch(16'd1);
      fetch(16'd0);
      idle();

      q.delete();
      for (int i = 0; i < 64; i++) q.push_back(8'($urandom));
      q.push_back(8'hAA);
      do_load(q, 0, 0);
      fetch(16'd15);
      fetch(16'd7);
      fetch(16'd0);
      idle();

      for (int it = 0; it < 8; it++) begin
         q.delete();
         for (int i = 0; i < $urandom_range(0, 70); i++)
            q.push_back(8'($urandom));
         do_load(q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         for (int r = 0; r < $urandom_range(1, 5); r++)
            fetch(pick_addr());
         idle();
         repeat (2) tick();
         check_status();
      end

      start_load(0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      #2;
      Reset = 1'b0;
      #1;
      m_busy = 0;
      m_wc   = 0;
      m_err  = 0;
      pend.delete();
      chk("midrst_ready", oLoadByteReady, 1'b0);
      chk("midrst_valid", oInstructionValid, 1'b0);
      check_status();
      #2;
      Reset = 1'b1;
      tick();
      fetch(16'd0);
      fetch(pick_addr());
      fetch(16'd15);
      idle();
      check_status();

      repeat (3) tick();
      chk("scoreboard_drained", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/prog_mem.md
Name: prog_mem

Overview:
- Parametrised, writable successor to the fixed combinational instruction ROM; sits between the PC/fetch logic and the decode stage of the MiniALU core.
- Holds DEPTH instruction words of DATA_WIDTH bits and returns them with a registered, one-cycle read.
- A byte-stream loader fills the memory at run time from a host/UART path, so programs change without resynthesis.
- Out-of-range or blocked fetches return the default (LED-pattern) word, as the ROM did.

Parameters:
- DATA_WIDTH, 28, instruction word width (opcode/dest/src1/src2 or opcode/dest/16-bit literal).
- DEPTH, 64, number of words; legal addresses 0..DEPTH-1.
- DEFAULT_WORD, {`LED, 24'b10101010}, word returned for out-of-range, blocked or reset fetches.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iAddress  in  16  fetch address from the PC.
- iReadEnable  in  1  fetch request.
- oInstruction  out  DATA_WIDTH  fetched word.
- oInstructionValid  out  1  oInstruction holds a real fetch result.
- iLoadStart  in  1  one-cycle pulse that enters load mode.
- iLoadByte  in  8  load data byte.
- iLoadByteValid  in  1  iLoadByte is valid.
- oLoadByteReady  out  1  block accepts a byte this cycle.
- iLoadEnd  in  1  one-cycle pulse that ends load mode.
- oBusy  out  1  high while in load mode.
- oWordCount  out  16  words written in the current or last load.
- oLoadError  out  1  sticky: partial word dropped, or overflow attempted.

Behaviour:
- Reset (Reset=0, async):
  - State S_RUN.
  - oInstruction=DEFAULT_WORD; oInstructionValid=0.
  - oLoadByteReady=0, oBusy=0, oWordCount=0, oLoadError=0.
  - Byte counter=0; write pointer=0.
  - Memory array is not cleared.
- S_RUN, iReadEnable=1:
  - Next edge: oInstruction=mem[iAddress] and oInstructionValid=1.
  - If iAddress>=DEPTH: oInstruction=DEFAULT_WORD, oInstructionValid=1.
- S_RUN, iReadEnable=0: oInstructionValid=0 next cycle; oInstruction holds its value.
- Read latency: exactly 1 cycle; back-to-back reads give one result per cycle.
- S_RUN + iLoadStart:
  - Next state S_LOAD.
  - Write pointer=0, byte counter=0, oWordCount=0, oLoadError=0.
  - A read requested in the same cycle is still serviced.
- S_LOAD:
  - oBusy=1.
  - Every read returns DEFAULT_WORD with oInstructionValid=0.
  - iLoadStart is ignored.
- Byte acceptance: a byte is accepted when iLoadByteValid & oLoadByteReady.
  - oLoadByteReady=1 in S_LOAD while write pointer<DEPTH.
- Word packing:
  - BYTES=ceil(DATA_WIDTH/8); bytes are packed little-endian, byte k into bits [8k+7:8k].
  - Bits of the last byte above DATA_WIDTH are discarded.
  - The edge that accepts byte BYTES-1 writes the word to mem[write pointer], increments the pointer and oWordCount, and clears the byte counter.
- Full: write pointer==DEPTH.
  - oLoadByteReady=0.
  - A byte offered (iLoadByteValid=1) sets oLoadError; the block stays in S_LOAD until iLoadEnd.
- iLoadEnd in S_LOAD:
  - A byte accepted in the same cycle is processed first, including a word write if it completes one.
  - Then return to S_RUN.
  - If the byte counter is non-zero after that byte, the partial word is discarded and oLoadError is set.
- Reset mid-load: immediate return to S_RUN.
  - Words already written stay in memory.
  - oWordCount=0.
- oWordCount and oLoadError hold their values in S_RUN until the next iLoadStart.

Decomposition:
- Shared definitions header (existing Definitions file), which gains:
  - state encodings S_RUN / S_LOAD;
  - a `DEFAULT_INSTR macro ({`LED, 24'b10101010});
  - the byte-count width macro.
- One natural sub-module, byte_assembler:
  - accumulates BYTES bytes;
  - outputs the packed word plus a one-cycle word_done strobe;
  - has a flush input that discards a partial word and reports it.
- The memory array stays inline as a synchronous-write, registered-read array.

Test Plan (DATA_WIDTH=28, DEPTH=16):
- Reset, then read addr 3 with no load -> oInstruction=28'h40000AA (`LED=0x4`), oInstructionValid=0 until the first fetch.
- Load start; bytes 05,00,01,09; load end; read addr 0 -> one cycle later oInstruction=28'h9010005, oInstructionValid=1; oWordCount=1; oLoadError=0.
- Read addr 16 and addr 0xFFFF -> DEFAULT_WORD with valid=1; back-to-back reads of addrs 0,1,0 give results on three consecutive cycles.
- Load 6 bytes then load end -> oWordCount=1, oLoadError=1; addr 1 keeps its previous content.
- Load 64 bytes, then offer byte 0xAA -> oLoadByteReady=0 after 16 words; oLoadError=1; addr 15 holds the word packed from bytes 60..63.
- Reset asserted after 2 of 4 load bytes -> oBusy=0 and oWordCount=0 immediately; earlier words intact; a read of addr 0 in S_RUN is valid next cycle.
